// File: rtl/ext_pipe_if.sv
// Handshake bundle between an upstream producer, ext_pipe and its consumer.
// master = the side that offers immediates and consumes results.
// slave  = ext_pipe itself.
interface ext_pipe_if #(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       ext_op;
    logic [IMM_W-1:0] imm;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport master (
        output in_valid, ext_op, imm, flush, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, ext_op, imm, flush, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/ext_pipe.sv
// Immediate extension stage: zero/sign/upper/shifted-sign extension of an
// IMM_W-bit field to OUT_W bits, registered behind a two-entry skid buffer.
//
// Handshake: a beat moves on a side only in a cycle where valid && ready are
// both high at the rising edge. valid must not depend on ready; ready on the
// input side comes straight from a flop, so there is no combinational path
// from out_ready to in_ready. Once out_valid is up, out_data is held until
// the beat is taken.
module ext_pipe #(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2
) (
    input  logic       clk,
    input  logic       reset,
    ext_pipe_if.slave  bus,
    output logic [1:0] dbg_state
);

    // Reject illegal width/shift combinations at elaboration time.
    if (OUT_W <= IMM_W) begin : g_bad_width
        $error("ext_pipe: OUT_W must be greater than IMM_W");
    end
    if (SHIFT < 0 || SHIFT >= OUT_W) begin : g_bad_shift
        $error("ext_pipe: SHIFT must be in 0..OUT_W-1");
    end

    localparam int PAD_W = OUT_W - IMM_W;

    // EMPTY: nothing held; ONE: output reg valid; FULL: output + skid valid.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             in_ready_q;
    logic [OUT_W-1:0] out_q;
    logic [OUT_W-1:0] skid_q;
    logic [OUT_W-1:0] result;
    logic [OUT_W-1:0] sext;
    logic             xfer_in;
    logic             xfer_out;

    assign xfer_in      = bus.in_valid && in_ready_q;
    assign xfer_out     = bus.out_valid && bus.out_ready;
    assign bus.in_ready = in_ready_q;
    assign bus.out_valid = (state != S_EMPTY);
    assign bus.out_data = out_q;
    assign dbg_state    = state;

    // Extend the incoming immediate according to ext_op.
    always_comb begin
        sext   = {{PAD_W{bus.imm[IMM_W-1]}}, bus.imm};
        result = '0;
        case (bus.ext_op)
            2'd0:    result = {{PAD_W{1'b0}}, bus.imm};
            2'd1:    result = sext;
            2'd2:    result = {bus.imm, {PAD_W{1'b0}}};
            default: result = sext << SHIFT;
        endcase
    end

    // Occupancy transitions; flush empties the pipe regardless of traffic.
    always_comb begin
        state_next = state;
        if (bus.flush) begin
            state_next = S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: if (xfer_in) state_next = S_ONE;
                S_ONE: begin
                    if (xfer_in && !xfer_out)      state_next = S_FULL;
                    else if (!xfer_in && xfer_out) state_next = S_EMPTY;
                end
                S_FULL:  if (xfer_out) state_next = S_ONE;
                default: state_next = S_EMPTY;
            endcase
        end
    end

    // State register; in_ready is re-registered from the next occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_next;
            in_ready_q <= (state_next != S_FULL);
        end
    end

    // Result storage: output register plus skid register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_q  <= '0;
            skid_q <= '0;
        end else if (!bus.flush) begin
            case (state)
                S_EMPTY: if (xfer_in) out_q <= result;
                S_ONE: begin
                    if (xfer_in && xfer_out) out_q  <= result;
                    else if (xfer_in)        skid_q <= result;
                end
                S_FULL:  if (xfer_out) out_q <= skid_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// Randomized and directed bench for ext_pipe, with a queue-based reference
// model of the pipe contents and an arithmetic model of the extension modes.
module tb_ext_pipe;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    logic [1:0] dbg_state2;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];

    ext_pipe_if #(.IMM_W(16), .OUT_W(32)) bus ();
    ext_pipe_if #(.IMM_W(8),  .OUT_W(16)) bus2 ();

    ext_pipe #(.IMM_W(16), .OUT_W(32), .SHIFT(2)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    ext_pipe #(.IMM_W(8), .OUT_W(16), .SHIFT(1)) dut2 (
        .clk       (clk),
        .reset     (rst_n),
        .bus       (bus2.slave),
        .dbg_state (dbg_state2)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    // Extension reference: plain integer arithmetic on the mode rules.
    function automatic logic [31:0] ref_ext(input int iw, input int ow, input int sh,
                                            input int op, input logic [31:0] imm);
        longint unsigned m_in, m_out, v;
        m_in  = (64'd1 << iw) - 64'd1;
        m_out = (64'd1 << ow) - 64'd1;
        v     = {32'd0, imm} & m_in;
        if ((op == 1 || op == 3) && (((v >> (iw - 1)) & 64'd1) != 64'd0)) v = v | ~m_in;
        if (op == 2) v = v << (ow - iw);
        if (op == 3) v = v << sh;
        v = v & m_out;
        return v[31:0];
    endfunction

    // One clock of traffic on the main DUT. Outputs are checked against the
    // model at the negedge, then inputs are applied for the next posedge.
    task automatic do_cycle(input logic iv, input logic [1:0] op, input logic [15:0] im,
                            input logic fl, input logic ordy);
        logic xin, xout;
        @(negedge clk);
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_q.size() != 0});
        chk("in_ready",  {31'd0, bus.in_ready},  {31'd0, exp_q.size() < 2});
        if (exp_q.size() != 0) chk("out_data", bus.out_data, exp_q[0]);
        bus.in_valid  = iv;
        bus.ext_op    = op;
        bus.imm       = im;
        bus.flush     = fl;
        bus.out_ready = ordy;
        xin  = iv && (exp_q.size() < 2);
        xout = ordy && (exp_q.size() != 0);
        if (xout) void'(exp_q.pop_front());
        if (fl) exp_q.delete();
        else if (xin) exp_q.push_back(ref_ext(16, 32, 2, int'(op), {16'd0, im}));
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("rst_out_data",  bus.out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic small_vec(input logic [1:0] op, input logic [7:0] im, input logic [15:0] lit);
        @(negedge clk);
        bus2.in_valid = 1'b1;
        bus2.ext_op   = op;
        bus2.imm      = im;
        @(negedge clk);
        bus2.in_valid = 1'b0;
        chk("p_valid", {31'd0, bus2.out_valid}, 32'd1);
        chk("p_model", {16'd0, bus2.out_data}, ref_ext(8, 16, 1, int'(op), {24'd0, im}));
        chk("p_const", {16'd0, bus2.out_data}, {16'd0, lit});
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.ext_op = 2'd0; bus.imm = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.ext_op = 2'd0; bus2.imm = '0; bus2.flush = 1'b0; bus2.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("init_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("init_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("init_out_data",  bus.out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed modes, one cycle after transfer in.
        do_cycle(1, 2'd0, 16'h8000, 0, 1); chk("mode0", bus.out_data, 32'h0000_8000);
        do_cycle(1, 2'd1, 16'h8000, 0, 1); chk("mode1", bus.out_data, 32'hFFFF_8000);
        do_cycle(1, 2'd2, 16'h1234, 0, 1); chk("mode2", bus.out_data, 32'h1234_0000);
        do_cycle(1, 2'd3, 16'hFFFF, 0, 1); chk("mode3", bus.out_data, 32'hFFFF_FFFC);
        do_cycle(0, 2'd0, 16'h0, 0, 1);

        // Backpressure: third item refused, then drain in order.
        do_cycle(1, 2'd0, 16'h0001, 0, 0);
        do_cycle(1, 2'd0, 16'h0002, 0, 0);
        do_cycle(1, 2'd0, 16'h0003, 0, 0);
        chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_hold", bus.out_data, 32'h1);
        do_cycle(1, 2'd0, 16'h0003, 0, 0);
        chk("bp_stable", bus.out_data, 32'h1);
        do_cycle(0, 2'd0, 16'h0, 0, 1); chk("bp_out2", bus.out_data, 32'h2);
        do_cycle(1, 2'd0, 16'h0003, 0, 1); chk("bp_out3", bus.out_data, 32'h3);
        do_cycle(0, 2'd0, 16'h0, 0, 1);
        do_cycle(0, 2'd0, 16'h0, 0, 1);

        // Streaming: 100 random items at full rate.
        for (int i = 0; i < 100; i++)
            do_cycle(1, 2'($urandom_range(0, 3)), 16'($urandom), 0, 1);
        do_cycle(0, 2'd0, 16'h0, 0, 1);
        do_cycle(0, 2'd0, 16'h0, 0, 1);

        // Flush in FULL with an item offered.
        do_cycle(1, 2'd1, 16'h00AA, 0, 0);
        do_cycle(1, 2'd1, 16'h00BB, 0, 0);
        do_cycle(1, 2'd1, 16'h00CC, 1, 0);
        chk("fl_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("fl_in_ready",  {31'd0, bus.in_ready},  32'd1);
        do_cycle(1, 2'd0, 16'h0055, 0, 1); chk("fl_after", bus.out_data, 32'h55);
        do_cycle(0, 2'd0, 16'h0, 0, 1);

        // Reset while FULL, then normal processing.
        do_cycle(1, 2'd2, 16'h1111, 0, 0);
        do_cycle(1, 2'd2, 16'h2222, 0, 0);
        apply_reset();
        do_cycle(1, 2'd3, 16'h0004, 0, 1); chk("rst_after", bus.out_data, 32'h10);
        do_cycle(0, 2'd0, 16'h0, 0, 1);

        // Random traffic with occasional flush.
        for (int i = 0; i < 400; i++)
            do_cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
                     ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)));
        do_cycle(0, 2'd0, 16'h0, 0, 1);
        do_cycle(0, 2'd0, 16'h0, 0, 1);
        do_cycle(0, 2'd0, 16'h0, 0, 1);

        // Narrow configuration.
        small_vec(2'd1, 8'h80, 16'hFF80);
        small_vec(2'd3, 8'h80, 16'hFF00);
        small_vec(2'd2, 8'h80, 16'h8000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ext_pipe.md
EXT_PIPE -- requirements
Module: ext_pipe

Interface
REQ-001 Parameter IMM_W, default 16, immediate field width in bits.
REQ-002 Parameter OUT_W, default 32, extended result width in bits; OUT_W > IMM_W is legal, otherwise illegal (elaboration error).
REQ-003 Parameter SHIFT, default 2, left-shift amount for branch-offset mode; 0 <= SHIFT < OUT_W.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-006 in_valid  input  1  upstream offers ext_op/imm this cycle.
REQ-007 in_ready  output  1  block can accept an input this cycle.
REQ-008 ext_op  input  2  mode: 0 zero-ext, 1 sign-ext, 2 upper-load, 3 sign-ext shifted by SHIFT.
REQ-009 imm  input  IMM_W  raw immediate field.
REQ-010 flush  input  1  discard all held and incoming items.
REQ-011 out_valid  output  1  out_data holds a valid result.
REQ-012 out_ready  input  1  downstream accepts out_data this cycle.
REQ-013 out_data  output  OUT_W  extended immediate.

Function
REQ-014 Transfer in = in_valid && in_ready; transfer out = out_valid && out_ready.
REQ-015 Mode 0 SHALL produce imm in low IMM_W bits, upper bits zero.
REQ-016 Mode 1 SHALL replicate imm[IMM_W-1] into bits OUT_W-1..IMM_W.
REQ-017 Mode 2 SHALL place imm in bits OUT_W-1..OUT_W-IMM_W, lower OUT_W-IMM_W bits zero.
REQ-018 Mode 3 SHALL compute the mode-1 value shifted left by SHIFT, zero-filled, truncated to OUT_W bits (overflow bits discarded, no flag).
REQ-019 Result SHALL be computed at input transfer and registered; latency exactly 1 cycle from transfer in to out_valid (empty pipe).
REQ-020 Storage: one output register plus one skid register; states EMPTY (0 held), ONE (output reg valid), FULL (both valid).
REQ-021 in_ready SHALL equal NOT skid-valid, driven from a register (no combinational path from out_ready).
REQ-022 EMPTY: transfer in -> ONE.
REQ-023 ONE: transfer in without transfer out -> FULL (new result to skid); transfer out without transfer in -> EMPTY; both -> ONE with new result in output reg.
REQ-024 FULL: in_ready=0; transfer out -> ONE, skid contents move to output reg next cycle.
REQ-025 Ordering SHALL be strict FIFO; no result dropped or duplicated absent flush/reset.
REQ-026 out_data SHALL remain stable while out_valid && !out_ready.
REQ-027 flush asserted: next cycle state EMPTY, out_valid=0, in_ready=1; an input offered in the flush cycle is discarded; a transfer out in the flush cycle still completes.
REQ-028 out_data when out_valid=0 SHALL hold its last value (don't-care for checking except after reset).

Reset
REQ-029 reset=0 at a rising edge SHALL set state EMPTY, out_valid=0, out_data=0, skid register=0, in_ready=1 from next cycle.
REQ-030 reset overrides flush and any transfer in the same cycle; items in flight mid-operation are lost.
REQ-031 No output SHALL be X after the first reset edge.

Verification (IMM_W=16, OUT_W=32, SHIFT=2)
REQ-032 Modes, out_ready=1: imm=0x8000 op0 -> 0x00008000; op1 -> 0xFFFF8000; imm=0x1234 op2 -> 0x12340000; imm=0xFFFF op3 -> 0xFFFFFFFC; each one cycle after transfer in.
REQ-033 Backpressure: out_ready=0, send 0x0001,0x0002,0x0003 op0 back-to-back -> first two accepted, in_ready=0 at third; release out_ready -> outputs 0x1,0x2,0x3 in order, out_data stable while stalled.
REQ-034 Streaming: in_valid=1, out_ready=1 continuously for 100 random items -> one result per cycle, in_ready never drops, order preserved.
REQ-035 Flush in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered item never appears at output.
REQ-036 Reset mid-operation in FULL state with reset=0 for one edge -> out_valid=0, out_data=0x00000000, in_ready=1; subsequent item processes normally.
REQ-037 Parameter sweep IMM_W=8, OUT_W=16, SHIFT=1: imm=0x80 op1 -> 0xFF80; op3 -> 0xFF00; op2 -> 0x8000.
